// File: rtl/ads127l01_frame_packer.sv
// Packs ADC samples into DMA frames: a header word, the samples sign-extended
// to 32 bits, then a trailer word that carries the clip count and frame length.
module ads127l01_frame_packer #(
    parameter int DW = 24,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic          s_axis_tlast,
    input  logic [DW-1:0] s_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          m_axis_tlast,
    output logic [31:0]   m_axis_tdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, HDR, DATA, TRL} state_t;

    localparam logic [DW-1:0] MAX_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] MAX_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CW-1:0] LEN_MAX = '1;

    state_t        state_q, state_d;
    logic          tvalid_q, tvalid_d;
    logic          tlast_q, tlast_d;
    logic [31:0]   tdata_q, tdata_d;
    logic [7:0]    seq_q, seq_d;
    logic [CW-1:0] len_q, len_d;
    logic [7:0]    clip_q, clip_d;

    logic          slot_free;
    logic          accept;
    logic          is_clip;
    logic [15:0]   len16;

    // The output register may be overwritten only once its word is gone or leaving now.
    assign slot_free     = !tvalid_q || m_axis_tready;
    assign s_axis_tready = (state_q == DATA) && slot_free;
    assign accept        = s_axis_tready && s_axis_tvalid;
    assign is_clip       = (s_axis_tdata == MAX_POS) || (s_axis_tdata == MAX_NEG);
    assign len16         = 16'(len_q);

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tdata  = tdata_q;
    assign busy          = (state_q != IDLE);

    always_comb begin
        // NOTE: every next-state value gets a default first, so no path can infer a latch.
        state_d  = state_q;
        tvalid_d = tvalid_q && !m_axis_tready;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        seq_d    = seq_q;
        len_d    = len_q;
        clip_d   = clip_q;

        case (state_q)
            IDLE: begin
                if (en && s_axis_tvalid) state_d = HDR;
            end
            HDR: begin
                if (slot_free) begin
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = {8'hA5, seq_q, 16'h0000};
                    len_d    = '0;
                    clip_d   = '0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = 32'($signed(s_axis_tdata));
                    len_d    = (len_q == LEN_MAX) ? len_q : len_q + 1'b1;
                    if (is_clip && clip_q != 8'hFF) clip_d = clip_q + 8'd1;
                    if (s_axis_tlast) state_d = TRL;
                end
            end
            TRL: begin
                if (slot_free) begin
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                    tdata_d  = {8'h5A, clip_q, len16};
                    seq_d    = seq_q + 8'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
            seq_q    <= '0;
            len_q    <= '0;
            clip_q   <= '0;
        end else begin
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            seq_q    <= seq_d;
            len_q    <= len_d;
            clip_q   <= clip_d;
        end
    end

endmodule

// File: tb/tb_ads127l01_frame_packer.sv
// Bench for ads127l01_frame_packer: a frame-level model predicts the output word
// stream, a monitor compares every transferred word, and literal words pin the model.
module tb_ads127l01_frame_packer;

    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] s_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [31:0]   m_axis_tdata;
    logic          busy;

    ads127l01_frame_packer #(.DW(DW), .CW(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    bit          bp = 1'b0;
    logic [7:0]  seq_m = 8'h00;
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    logic [23:0] samp[$];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    // Two's-complement sign extension done with integer arithmetic.
    function automatic logic [31:0] sext(input logic [23:0] s);
        int v;
        v = int'({8'h00, s});
        if (v >= 32'h0080_0000) v = v - 32'h0100_0000;
        return 32'(v);
    endfunction

    // Drives one frame (or a partial one) and extends the expected word stream.
    task automatic run_frame(input int n_send, input bit has_last, input int drop_en_at);
        int clip_cnt = 0;
        exp_q.push_back({1'b0, 8'hA5, seq_m, 16'h0000});
        en = 1'b1;
        for (int i = 0; i < n_send; i++) begin
            int c = 0;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = samp[i];
            s_axis_tlast  = has_last && (i == n_send - 1);
            if (i == drop_en_at) en = 1'b0;
            exp_q.push_back({1'b0, sext(samp[i])});
            if (samp[i] == 24'h7FFFFF || samp[i] == 24'h800000) clip_cnt++;
            while (1) begin
                @(negedge clk);
                if (s_axis_tready) break;
                c++;
                if (c > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL s_ready_timeout: sample %0d never accepted, required acceptance", i);
                    finish_run();
                end
            end
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        en            = 1'b0;
        if (has_last) begin
            exp_q.push_back({1'b1, 8'h5A, (clip_cnt > 255) ? 8'hFF : 8'(clip_cnt), 16'(n_send)});
            seq_m = seq_m + 8'd1;
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_axis_tvalid) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        finish_run();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        seq_m = 8'h00;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every transferred word against the model, and stability while stalled.
    initial begin : monitor
        logic        stall;
        logic [32:0] prev;
        stall = 1'b0;
        prev  = '0;
        forever begin
            @(negedge clk);
            if (stall) begin
                check("hold_valid", {32'b0, m_axis_tvalid}, 33'd1);
                check("hold_word", {m_axis_tlast, m_axis_tdata}, prev);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_q.push_back({m_axis_tlast, m_axis_tdata});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %h expected no word", {m_axis_tlast, m_axis_tdata});
                end else begin
                    check("out_word", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
                end
            end
            stall = m_axis_tvalid && !m_axis_tready && !rst;
            prev  = {m_axis_tlast, m_axis_tdata};
        end
    end

    initial begin
        #2_000_000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        finish_run();
    end

    initial begin
        logic [32:0] lit6[6];
        rst           = 1'b1;
        en            = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {29'b0, m_axis_tvalid, m_axis_tlast, busy, s_axis_tready}, 33'd0);
        check("reset_data", {1'b0, m_axis_tdata}, 33'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reference frame with both full-scale codes.
        samp = '{24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000};
        got_q.delete();
        run_frame(4, 1'b1, -1);
        wait_drain();
        lit6 = '{33'h0_A5000000, 33'h0_00000001, 33'h0_FFFFFFFF,
                 33'h0_007FFFFF, 33'h0_FF800000, 33'h1_5A020004};
        check("ref_count", 33'(got_q.size()), 33'd6);
        foreach (lit6[i]) if (i < got_q.size()) check("ref_word", got_q[i], lit6[i]);

        // Three single-sample frames with incrementing sequence numbers.
        do_reset();
        got_q.delete();
        samp = '{24'h000123};
        for (int f = 0; f < 3; f++) run_frame(1, 1'b1, -1);
        wait_drain();
        check("one_count", 33'(got_q.size()), 33'd9);
        if (got_q.size() == 9) begin
            check("one_hdr0", got_q[0], 33'h0_A5000000);
            check("one_hdr1", got_q[3], 33'h0_A5010000);
            check("one_hdr2", got_q[6], 33'h0_A5020000);
            check("one_trl0", got_q[2], 33'h1_5A000001);
            check("one_trl2", got_q[8], 33'h1_5A000001);
        end

        // Disabled packer must ignore offered samples.
        en            = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'h000777;
        repeat (12) begin
            @(negedge clk);
            check("idle_quiet", {30'b0, s_axis_tready, m_axis_tvalid, busy}, 33'd0);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;

        // Long frame under random backpressure; enable dropped mid-frame.
        samp.delete();
        for (int i = 0; i < 1000; i++) samp.push_back(24'((i * 37) & 32'h003F_FFFF));
        got_q.delete();
        bp = 1'b1;
        run_frame(1000, 1'b1, 10);
        wait_drain();
        bp = 1'b0;
        check("long_count", 33'(got_q.size()), 33'd1002);
        if (got_q.size() == 1002) check("long_trl", got_q[1001], 33'h1_5A0003E8);

        // Reset after five samples: partial frame discarded, sequence restarts.
        repeat (2) @(posedge clk);
        #1;
        samp = '{24'h000011, 24'h000022, 24'h000033, 24'h000044, 24'h000055};
        run_frame(5, 1'b0, -1);
        do_reset();
        @(negedge clk);
        check("abort_ctrl", {30'b0, m_axis_tvalid, busy, s_axis_tready}, 33'd0);
        check("abort_no_trl", 33'(exp_q.size()), 33'd0);
        got_q.delete();
        samp = '{24'h000010};
        run_frame(1, 1'b1, -1);
        wait_drain();
        check("abort_next_hdr", got_q.size() > 0 ? got_q[0] : 33'h0, 33'h0_A5000000);

        // Sequence wrap, then a frame saturating the clip counter.
        do_reset();
        samp = '{24'h000042};
        for (int f = 0; f < 256; f++) run_frame(1, 1'b1, -1);
        wait_drain();
        got_q.delete();
        samp.delete();
        for (int i = 0; i < 300; i++) samp.push_back(i[0] ? 24'h800000 : 24'h7FFFFF);
        run_frame(300, 1'b1, -1);
        wait_drain();
        check("wrap_count", 33'(got_q.size()), 33'd302);
        if (got_q.size() == 302) begin
            check("wrap_hdr", got_q[0], 33'h0_A5000000);
            check("clip_trl", got_q[301], 33'h1_5AFF012C);
        end

        finish_run();
    end

endmodule
